// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered fill count, almost-full/almost-empty thresholds,
// standard or first-word-fall-through read mode, and sticky overflow/underflow flags.
module sync_fifo_flags #(
    parameter int unsigned DATA_WIDTH          = 88,
    parameter int unsigned ADDRESS_WIDTH       = 7,
    parameter int unsigned FIFO_DEPTH          = 1 << ADDRESS_WIDTH,
    parameter int unsigned FWFT                = 0,
    parameter int unsigned ALMOST_FULL_THRESH  = FIFO_DEPTH - 4,
    parameter int unsigned ALMOST_EMPTY_THRESH = 4
) (
    input  logic                     Clk,
    input  logic                     Clear_in,
    input  logic [DATA_WIDTH-1:0]    Data_in,
    input  logic                     WriteEn_in,
    output logic                     Full_out,
    output logic                     AlmostFull_out,
    output logic [DATA_WIDTH-1:0]    Data_out,
    input  logic                     ReadEn_in,
    output logic                     Empty_out,
    output logic                     AlmostEmpty_out,
    output logic                     Valid_out,
    output logic [ADDRESS_WIDTH:0]   Count_out,
    output logic                     Overflow_out,
    output logic                     Underflow_out
);

    localparam int unsigned CW = ADDRESS_WIDTH + 1;

    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     full_q, full_d;
    logic                     empty_q, empty_d;
    logic                     afull_q, afull_d;
    logic                     aempty_q, aempty_d;
    logic                     ovf_q, ovf_d;
    logic                     udf_q, udf_d;
    logic                     rd_acc_c, wr_acc_c;

    logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];

    // A write into a full FIFO is accepted only alongside an accepted read; no read bypass when empty.
    always_comb begin
        rd_acc_c = ReadEn_in & ~empty_q;
        wr_acc_c = WriteEn_in & (~full_q | rd_acc_c);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (WriteEn_in & ~wr_acc_c);
        udf_d    = udf_q | (ReadEn_in & ~rd_acc_c);

        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d = rd_ptr_q + ADDRESS_WIDTH'(1);
        end

        case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flags are registered copies of comparisons on the post-edge count.
        full_d   = (count_d == CW'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CW'(ALMOST_FULL_THRESH));
        aempty_d = (count_d <= CW'(ALMOST_EMPTY_THRESH));
    end

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is never cleared; only the pointers are.
    always_ff @(posedge Clk) begin
        if (!Clear_in && wr_acc_c) begin
            mem_q[wr_ptr_q] <= Data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign Data_out  = mem_q[rd_ptr_q];
            assign Valid_out = ~empty_q;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_q, data_d;
            logic                  valid_q, valid_d;

            always_comb begin
                data_d  = data_q;
                valid_d = 1'b0;
                if (rd_acc_c) begin
                    data_d  = mem_q[rd_ptr_q];
                    valid_d = 1'b1;
                end
            end

            always_ff @(posedge Clk) begin
                if (Clear_in) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign Data_out  = data_q;
            assign Valid_out = valid_q;
        end
    endgenerate

    assign Full_out        = full_q;
    assign Empty_out       = empty_q;
    assign AlmostFull_out  = afull_q;
    assign AlmostEmpty_out = aempty_q;
    assign Count_out       = count_q;
    assign Overflow_out    = ovf_q;
    assign Underflow_out   = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard and FWFT instances share stimulus and are checked
// every cycle against a queue-based model, plus directed literal checks.
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clr, we, re;
    logic [DW-1:0] din;

    logic          s_full, s_af, s_empty, s_ae, s_valid, s_ovf, s_udf;
    logic [DW-1:0] s_dout;
    logic [AW:0]   s_count;
    logic          f_full, f_af, f_empty, f_ae, f_valid, f_ovf, f_udf;
    logic [DW-1:0] f_dout;
    logic [AW:0]   f_count;

    sync_fifo_flags #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH), .FWFT(0),
                      .ALMOST_FULL_THRESH(AF), .ALMOST_EMPTY_THRESH(AE)) u_std (
        .Clk(clk), .Clear_in(clr), .Data_in(din), .WriteEn_in(we), .Full_out(s_full),
        .AlmostFull_out(s_af), .Data_out(s_dout), .ReadEn_in(re), .Empty_out(s_empty),
        .AlmostEmpty_out(s_ae), .Valid_out(s_valid), .Count_out(s_count),
        .Overflow_out(s_ovf), .Underflow_out(s_udf));

    sync_fifo_flags #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH), .FWFT(1),
                      .ALMOST_FULL_THRESH(AF), .ALMOST_EMPTY_THRESH(AE)) u_fwft (
        .Clk(clk), .Clear_in(clr), .Data_in(din), .WriteEn_in(we), .Full_out(f_full),
        .AlmostFull_out(f_af), .Data_out(f_dout), .ReadEn_in(re), .Empty_out(f_empty),
        .AlmostEmpty_out(f_ae), .Valid_out(f_valid), .Count_out(f_count),
        .Overflow_out(f_ovf), .Underflow_out(f_udf));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: contents as a queue, plus sticky errors and the standard-mode output register.
    logic [DW-1:0] m_q[$];
    bit            m_init  = 1'b0;
    bit            m_ovf   = 1'b0;
    bit            m_udf   = 1'b0;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_dout  = '0;

    task automatic model_apply();
        bit rd_ok, wr_ok;
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_dout = '0; m_init = 1'b1;
        end else if (m_init) begin
            rd_ok   = re && (m_q.size() != 0);
            wr_ok   = we && ((m_q.size() < DEPTH) || rd_ok);
            m_valid = rd_ok;
            if (rd_ok) m_dout = m_q.pop_front();
            if (wr_ok) m_q.push_back(din);
            if (we && !wr_ok) m_ovf = 1'b1;
            if (re && !rd_ok) m_udf = 1'b1;
        end
    endtask

    task automatic step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        we = w; re = r; clr = c; din = d;
        @(posedge clk);
        model_apply();
        #1;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int sz;
        if (m_init) begin
            sz = m_q.size();
            check("std_count",  32'(s_count), sz);
            check("std_empty",  s_empty, sz == 0);
            check("std_full",   s_full,  sz == DEPTH);
            check("std_afull",  s_af,    sz >= AF);
            check("std_aempty", s_ae,    sz <= AE);
            check("std_ovf",    s_ovf,   m_ovf);
            check("std_udf",    s_udf,   m_udf);
            check("std_valid",  s_valid, m_valid);
            check("std_dout",   s_dout,  m_dout);
            check("fwft_count", 32'(f_count), sz);
            check("fwft_empty", f_empty, sz == 0);
            check("fwft_full",  f_full,  sz == DEPTH);
            check("fwft_afull", f_af,    sz >= AF);
            check("fwft_aempty", f_ae,   sz <= AE);
            check("fwft_ovf",   f_ovf,   m_ovf);
            check("fwft_udf",   f_udf,   m_udf);
            check("fwft_valid", f_valid, sz != 0);
            if (sz != 0) check("fwft_dout", f_dout, m_q[0]);
        end
    end

    initial begin
        int wp, rp;
        clr = 1'b0; we = 1'b0; re = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;

        // Clear with a concurrent write request.
        step(1, 0, 1, 8'h77);
        check("rst_count", 32'(s_count), 0);
        check("rst_empty", s_empty, 1);
        check("rst_aempty", s_ae, 1);
        check("rst_full", s_full, 0);
        check("rst_afull", s_af, 0);
        check("rst_valid", s_valid, 0);
        check("rst_ovf", s_ovf, 0);
        check("rst_udf", s_udf, 0);
        check("rst_fwft_valid", f_valid, 0);

        // Fill and overflow.
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 0, 8'(i));
            check("fill_aempty", s_ae, (i <= 2) ? 1 : 0);
            check("fill_afull", s_af, (i >= 6) ? 1 : 0);
            check("fill_full", s_full, (i == 8) ? 1 : 0);
            if (i == 1) check("fwft_first_word", f_dout, 8'h01);
        end
        step(1, 0, 0, 8'h09);
        check("ovf_set", s_ovf, 1);
        check("ovf_count", 32'(s_count), 8);

        // Drain order and underflow.
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 0, 8'h00);
            check("drain_data", s_dout, i);
            check("drain_valid", s_valid, 1);
        end
        step(0, 1, 0, 8'h00);
        check("udf_valid", s_valid, 0);
        check("udf_set", s_udf, 1);
        check("udf_dout_hold", s_dout, 8'h08);

        // Simultaneous read and write while full.
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(8'h10 + i));
        step(1, 1, 0, 8'h20);
        check("rw_full_count", 32'(s_count), 8);
        check("rw_full_ovf", s_ovf, 0);
        check("rw_full_dout", s_dout, 8'h10);

        // Simultaneous read and write while empty.
        step(0, 0, 1, 8'h00);
        step(1, 1, 0, 8'h33);
        check("rw_empty_count", 32'(s_count), 1);
        check("rw_empty_udf", s_udf, 1);
        check("rw_empty_valid", s_valid, 0);
        check("rw_empty_fwft", f_dout, 8'h33);

        // Streaming across pointer wrap.
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h40 + i));
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 0, 8'(8'h44 + k));
            check("wrap_count", 32'(s_count), 4);
            check("wrap_dout", s_dout, 8'(8'h40 + k));
        end

        // FWFT fall-through, pop, and clear with data held.
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'hA5);
        check("fwft_a5_data", f_dout, 8'hA5);
        check("fwft_a5_valid", f_valid, 1);
        step(0, 1, 0, 8'h00);
        check("fwft_pop_empty", f_empty, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'hC0 + i));
        step(0, 0, 1, 8'h00);
        check("fwft_clr_valid", f_valid, 0);
        check("fwft_clr_count", 32'(f_count), 0);

        // Random traffic with shifting bias and occasional clears.
        for (int k = 0; k < 1200; k++) begin
            wp = ((k / 150) % 2 == 0) ? 70 : 30;
            rp = 100 - wp;
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                 $urandom_range(0, 199) == 0, 8'($urandom));
        end

        step(0, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
